sr_init_ctrl: RTL and testbench
===============================

# sr_init_ctrl

Synchronous controller that loads an arbitrary initial value into a bank of set/reset flip-flops (dfsrtp-class cells) through their asynchronous RN/SN pins. It sits directly upstream of the register bank. It gates the bank's clock, drives per-bit active-low RN/SN pulses of a guaranteed width, and holds a recovery window before re-enabling the clock. RN and SN are never both driven low on the same bit.

## Interface

Parameters:
- WIDTH, 8, number of downstream flops (bits of INIT, RN, SN).
- PULSE_CYC, 2, RN/SN low-pulse width in CLK cycles; legal range ≥1.
- RECOV_CYC, 2, recovery cycles after release before CLK_EN returns high; legal range ≥1.

Ports:
- CLK  in  1  sole clock. All logic is on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- REQ  in  1  init request. Sampled only in IDLE.
- INIT  in  WIDTH  value to load. Captured on the edge that accepts REQ.
- BUSY  out  1  high from the cycle after acceptance through the last RELEASE cycle.
- ACK  out  1  one-cycle pulse: load complete.
- CLK_EN  out  1  enable for the downstream clock gate. Low while async pins are active or recovering.
- RN  out  WIDTH  per-bit active-low reset to the bank.
- SN  out  WIDTH  per-bit active-low set to the bank.

## Operation

- All outputs come directly from flops, with no combinational decode on RN/SN/CLK_EN, so the async pins are glitch-free.
- State machine, with states IDLE, GATE, ASSERT, RELEASE and DONE:
  - IDLE: RN=SN=all ones, CLK_EN=1, BUSY=0, ACK=0. If REQ=1, capture INIT into init_q and go to GATE.
  - GATE (1 cycle): CLK_EN=0, BUSY=1, RN/SN still all ones. This guarantees no bank clock edge coincides with async assertion. Next state is ASSERT.
  - ASSERT (PULSE_CYC cycles): RN=init_q, SN=~init_q. Bits with init 0 are reset and bits with init 1 are set. Next state is RELEASE.
  - RELEASE (RECOV_CYC cycles): RN=SN=all ones, CLK_EN=0, BUSY=1. Next state is DONE.
  - DONE (1 cycle): ACK=1, CLK_EN=1, BUSY=0. Next state is IDLE unconditionally. REQ is not accepted in DONE.
- A single down-counter of width $clog2(max(PULSE_CYC,RECOV_CYC)+1) times both ASSERT and RELEASE. It loads PULSE_CYC-1 on entry to ASSERT and RECOV_CYC-1 on entry to RELEASE. The state exits when the count is 0.
- Invariant: (~RN & ~SN) == 0 on every cycle, including reset and every state transition.
- REQ and INIT changes while not in IDLE are ignored. init_q is stable from acceptance until DONE.

## Timing

- Reset, sampled at any edge: the next state is IDLE. RN=SN=all ones, CLK_EN=1, BUSY=0, ACK=0, counter=0, init_q=0.
- Reset mid-operation, including during ASSERT: pins are released and CLK_EN=1 at the very next edge. The load is abandoned, no ACK is issued, and bank contents are undefined.
- Timeline with REQ sampled high at edge 0:
  - edge 1: GATE.
  - edges 2 through 1+PULSE_CYC: ASSERT.
  - next RECOV_CYC edges: RELEASE.
  - edge 2+PULSE_CYC+RECOV_CYC: DONE, with ACK high for one cycle.
  - following edge: IDLE.
- Request-to-ACK latency is 2+PULSE_CYC+RECOV_CYC edges (6 with defaults).
- With REQ held high continuously, back-to-back requests are re-accepted in the IDLE cycle after DONE. Period is 3+PULSE_CYC+RECOV_CYC.
- CLK_EN is low for exactly 1+PULSE_CYC+RECOV_CYC cycles per load.

## Test plan

- Defaults, INIT=8'hA5, one-cycle REQ at edge 0:
  - edge 1: CLK_EN=0, BUSY=1.
  - edges 2–3: RN=8'hA5, SN=8'h5A.
  - edges 4–5: RN=SN=8'hFF.
  - edge 6: ACK=1, CLK_EN=1, BUSY=0.
  - edge 7: IDLE.
- Accept INIT=8'h0F, then during ASSERT drive INIT=8'hF0 and pulse REQ → RN stays 8'h0F, SN stays 8'hF0, only one ACK, no second load.
- Assert RST for one cycle during the second ASSERT cycle → RN=SN=8'hFF and CLK_EN=1 at the next edge, ACK never pulses, BUSY=0.
- PULSE_CYC=1, RECOV_CYC=1, INIT=8'h00 → RN=8'h00 only at edge 2, ACK at edge 4, CLK_EN low for edges 1–3.
- REQ held high for 30 cycles with defaults → ACK at edges 6, 13, 20, 27.
- Random REQ/INIT/RST for 10k cycles, checked every cycle:
  - (~RN & ~SN) == 0.
  - CLK_EN is 0 whenever RN or SN is not all ones.
  - ACK is never high for two consecutive cycles.

Source files
------------

// File: rtl/sr_init_ctrl_if.sv
// Handshake and async-pin bundle between a load requester and sr_init_ctrl.
// The controller owns the slave side; the requester (or bench) owns the master side.
interface sr_init_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             req;
    logic [WIDTH-1:0] init;
    logic             busy;
    logic             ack;
    logic             clk_en;
    logic [WIDTH-1:0] rn;
    logic [WIDTH-1:0] sn;

    modport master (
        output req, init,
        input  busy, ack, clk_en, rn, sn
    );

    modport slave (
        input  req, init,
        output busy, ack, clk_en, rn, sn
    );
endinterface

// File: rtl/sr_init_ctrl.sv
// Loads an initial value into a bank of set/reset flops through their active-low
// RN/SN pins, gating the bank clock around the pulse and its recovery window.
module sr_init_ctrl #(
    parameter int WIDTH     = 8,
    parameter int PULSE_CYC = 2,
    parameter int RECOV_CYC = 2
) (
    input  logic          clk,
    input  logic          rst,
    sr_init_ctrl_if.slave bus
);

    localparam int MAX_CYC = (PULSE_CYC > RECOV_CYC) ? PULSE_CYC : RECOV_CYC;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0]    PULSE_LD = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]    RECOV_LD = CW'(RECOV_CYC - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ALL_ZERO = {WIDTH{1'b0}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GATE    = 3'd1,
        S_ASSERT  = 3'd2,
        S_RELEASE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t           state_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] init_q_r;
    logic             busy_r;
    logic             ack_r;
    logic             clk_en_r;
    logic [WIDTH-1:0] rn_r;
    logic [WIDTH-1:0] sn_r;

    assign bus.busy   = busy_r;
    assign bus.ack    = ack_r;
    assign bus.clk_en = clk_en_r;
    assign bus.rn     = rn_r;
    assign bus.sn     = sn_r;

    // Sequencer: every output is set for the state being entered, so the pins come straight off flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            cnt_r    <= '0;
            init_q_r <= ALL_ZERO;
            busy_r   <= 1'b0;
            ack_r    <= 1'b0;
            clk_en_r <= 1'b1;
            rn_r     <= ALL_ONES;
            sn_r     <= ALL_ONES;
        end else begin
            case (state_r)
                S_IDLE: begin
                    ack_r <= 1'b0;
                    rn_r  <= ALL_ONES;
                    sn_r  <= ALL_ONES;
                    if (bus.req) begin
                        init_q_r <= bus.init;
                        state_r  <= S_GATE;
                        busy_r   <= 1'b1;
                        clk_en_r <= 1'b0;
                    end else begin
                        busy_r   <= 1'b0;
                        clk_en_r <= 1'b1;
                    end
                end
                S_GATE: begin
                    // RN and SN are exact complements, so no bit ever sees both low.
                    state_r <= S_ASSERT;
                    cnt_r   <= PULSE_LD;
                    rn_r    <= init_q_r;
                    sn_r    <= ~init_q_r;
                end
                S_ASSERT: begin
                    if (cnt_r == '0) begin
                        state_r <= S_RELEASE;
                        cnt_r   <= RECOV_LD;
                        rn_r    <= ALL_ONES;
                        sn_r    <= ALL_ONES;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_RELEASE: begin
                    if (cnt_r == '0) begin
                        state_r  <= S_DONE;
                        ack_r    <= 1'b1;
                        busy_r   <= 1'b0;
                        clk_en_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    ack_r   <= 1'b0;
                end
                default: begin
                    state_r  <= S_IDLE;
                    cnt_r    <= '0;
                    busy_r   <= 1'b0;
                    ack_r    <= 1'b0;
                    clk_en_r <= 1'b1;
                    rn_r     <= ALL_ONES;
                    sn_r     <= ALL_ONES;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_init_ctrl.sv
// Scoreboard bench for sr_init_ctrl: directed loads push timestamped expectations,
// a negedge monitor pops and compares them and checks pin-safety invariants every cycle.
module tb_sr_init_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sr_init_ctrl_if #(.WIDTH(8)) bus0 ();
    sr_init_ctrl_if #(.WIDTH(8)) bus1 ();

    sr_init_ctrl #(.WIDTH(8), .PULSE_CYC(2), .RECOV_CYC(2)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    sr_init_ctrl #(.WIDTH(8), .PULSE_CYC(1), .RECOV_CYC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    typedef struct {
        int         cyc;
        logic       clk_en;
        logic       busy;
        logic       ack;
        logic [7:0] rn;
        logic [7:0] sn;
    } pin_t;

    typedef struct {
        int         cyc;
        logic [7:0] val;
    } ack_t;

    pin_t pq0[$];
    pin_t pq1[$];
    ack_t aq0[$];
    ack_t aq1[$];

    int         n_cmp = 0;
    int         n_bad = 0;
    bit         rand_mode = 1'b0;
    logic [7:0] ld [2];
    logic       pa [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req_v);
        end
    endtask

    task automatic exp_pins(input int id, input int c, input logic ce, input logic bz,
                            input logic ak, input logic [7:0] rn, input logic [7:0] sn);
        pin_t p;
        p.cyc = c; p.clk_en = ce; p.busy = bz; p.ack = ak; p.rn = rn; p.sn = sn;
        if (id == 0) pq0.push_back(p);
        else         pq1.push_back(p);
    endtask

    task automatic exp_ack(input int id, input int c, input logic [7:0] v);
        ack_t a;
        a.cyc = c; a.val = v;
        if (id == 0) aq0.push_back(a);
        else         aq1.push_back(a);
    endtask

    // Full default-timing load (PULSE_CYC=2, RECOV_CYC=2) with REQ sampled at the edge after cycle c.
    task automatic push_load(input int c, input logic [7:0] v);
        exp_pins(0, c + 1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(0, c + 2, 1'b0, 1'b1, 1'b0, v, ~v);
        exp_pins(0, c + 3, 1'b0, 1'b1, 1'b0, v, ~v);
        exp_pins(0, c + 4, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(0, c + 5, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(0, c + 6, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
        exp_pins(0, c + 7, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        exp_ack(0, c + 6, v);
    endtask

    task automatic mon(input int id, input logic ce, input logic bz, input logic ak,
                       input logic [7:0] rn, input logic [7:0] sn);
        pin_t p;
        ack_t a;
        bit   have_p = 1'b0;
        bit   have_a = 1'b0;
        chk($sformatf("rn_sn_overlap%0d", id), {24'h0, ~rn & ~sn}, 32'h0);
        chk($sformatf("clk_en_with_pins%0d", id), {31'h0, ((rn & sn) != 8'hFF) && ce}, 32'h0);
        chk($sformatf("ack_twice%0d", id), {31'h0, pa[id] && ak}, 32'h0);
        pa[id] = ak;
        if ((rn & sn) != 8'hFF) ld[id] = rn;
        if (id == 0) begin
            if (pq0.size() > 0 && pq0[0].cyc == cyc) begin p = pq0.pop_front(); have_p = 1'b1; end
        end else begin
            if (pq1.size() > 0 && pq1[0].cyc == cyc) begin p = pq1.pop_front(); have_p = 1'b1; end
        end
        if (have_p) begin
            chk($sformatf("clk_en%0d", id), {31'h0, ce}, {31'h0, p.clk_en});
            chk($sformatf("busy%0d", id),   {31'h0, bz}, {31'h0, p.busy});
            chk($sformatf("ack%0d", id),    {31'h0, ak}, {31'h0, p.ack});
            chk($sformatf("rn%0d", id),     {24'h0, rn}, {24'h0, p.rn});
            chk($sformatf("sn%0d", id),     {24'h0, sn}, {24'h0, p.sn});
        end
        if (ak && !rand_mode) begin
            if (id == 0) begin
                if (aq0.size() > 0) begin a = aq0.pop_front(); have_a = 1'b1; end
            end else begin
                if (aq1.size() > 0) begin a = aq1.pop_front(); have_a = 1'b1; end
            end
            if (have_a) begin
                chk($sformatf("ack_cycle%0d", id), cyc, a.cyc);
                chk($sformatf("loaded_value%0d", id), {24'h0, ld[id]}, {24'h0, a.val});
            end else begin
                chk($sformatf("unexpected_ack%0d", id), 32'h1, 32'h0);
            end
        end
    endtask

    // Monitor: samples both DUTs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            mon(0, bus0.clk_en, bus0.busy, bus0.ack, bus0.rn, bus0.sn);
            mon(1, bus1.clk_en, bus1.busy, bus1.ack, bus1.rn, bus1.sn);
        end
    end

    initial begin
        int c;
        pa[0] = 1'b0; pa[1] = 1'b0;
        ld[0] = 8'h00; ld[1] = 8'h00;
        rst = 1'b1;
        bus0.req = 1'b0; bus0.init = 8'h00;
        bus1.req = 1'b0; bus1.init = 8'h00;
        exp_pins(0, 2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        exp_pins(1, 2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single load of A5 with a one-cycle request; INIT changes afterwards are ignored.
        c = cyc;
        bus0.init = 8'hA5; bus0.req = 1'b1;
        push_load(c, 8'hA5);
        @(negedge clk);
        bus0.req = 1'b0; bus0.init = 8'h33;
        repeat (8) @(negedge clk);

        // REQ and INIT activity during ASSERT must not disturb the load or start another.
        c = cyc;
        bus0.init = 8'h0F; bus0.req = 1'b1;
        push_load(c, 8'h0F);
        exp_pins(0, c + 8, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        exp_pins(0, c + 9, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk);
        bus0.req = 1'b0;
        @(negedge clk);
        bus0.init = 8'hF0; bus0.req = 1'b1;
        @(negedge clk);
        bus0.req = 1'b0;
        repeat (8) @(negedge clk);

        // Reset during the second ASSERT cycle abandons the load with no ACK.
        c = cyc;
        bus0.init = 8'hC3; bus0.req = 1'b1;
        exp_pins(0, c + 1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(0, c + 2, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h3C);
        exp_pins(0, c + 3, 1'b0, 1'b1, 1'b0, 8'hC3, 8'h3C);
        for (int k = 4; k <= 9; k++) exp_pins(0, c + k, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        @(negedge clk);
        bus0.req = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);

        // Minimum pulse and recovery widths on the second instance, loading all zeros.
        c = cyc;
        bus1.init = 8'h00; bus1.req = 1'b1;
        exp_pins(1, c + 1, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(1, c + 2, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFF);
        exp_pins(1, c + 3, 1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF);
        exp_pins(1, c + 4, 1'b1, 1'b0, 1'b1, 8'hFF, 8'hFF);
        exp_pins(1, c + 5, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
        exp_ack(1, c + 4, 8'h00);
        @(negedge clk);
        bus1.req = 1'b0;
        repeat (7) @(negedge clk);

        // REQ held high for 30 cycles: loads repeat every 7 cycles.
        c = cyc;
        bus0.init = 8'h3C; bus0.req = 1'b1;
        for (int i = 0; i < 5; i++) push_load(c + 7 * i, 8'h3C);
        repeat (30) @(negedge clk);
        bus0.req = 1'b0;
        repeat (8) @(negedge clk);

        chk("pin_queue_drained", pq0.size() + pq1.size(), 32'h0);
        chk("ack_queue_drained", aq0.size() + aq1.size(), 32'h0);

        // Random REQ/INIT/RST; only the per-cycle invariants apply here.
        rand_mode = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            bus0.init = 8'($urandom_range(0, 255));
            bus0.req  = ($urandom_range(0, 3) == 0);
            bus1.init = 8'($urandom_range(0, 255));
            bus1.req  = ($urandom_range(0, 3) == 0);
            rst       = ($urandom_range(0, 40) == 0);
            @(negedge clk);
        end
        bus0.req = 1'b0; bus1.req = 1'b0; rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rand_mode = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
